pe_seq_ctrl: RTL and testbench

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
// PE sequencer: streams weights/activations from the global buffer into one PE and steps it
// through compute windows. Define PE_CTRL_WIN_SHIFT_EN to reuse activations via the PE shift.
module pe_seq_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WIN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [WIN_W-1:0]  num_win,
  output logic              gb_rd_en,
  output logic [ADDR_W-1:0] gb_addr,
  output logic              write_w_PE,
  output logic              write_a_PE,
  output logic              comp,
  output logic              shift,
  output logic              clear,
  output logic [2:0]        comp_idx,
  output logic [2:0]        write_idx,
  output logic              pe_out_valid,
  output logic              busy,
  output logic              done
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | GB reads (16 on first window, 8 activations on reloads)
  // TAIL   | write strobe for the final LOAD read
  // COMP   | 8 MAC steps, comp_idx 0..7
  // OUT    | PE result valid
  // CLR    | clear psum, advance window
  // SHIFT  | shift PE activations, fetch newest activation
  // FILL   | write newest activation into slot 7
  // DONE   | job-complete pulse
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_TAIL, S_COMP, S_OUT, S_CLR, S_SHIFT, S_FILL, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_w_base;
  logic [ADDR_W-1:0] r_a_base;
  logic [WIN_W-1:0]  r_num_win;
  logic [WIN_W-1:0]  r_win;
  logic [3:0]        r_cnt;
  logic              r_full;

  logic [WIN_W-1:0]  w_win_inc;
  logic              w_last;
  logic [3:0]        w_rd_idx;
  logic [3:0]        w_wr_idx;
  logic              w_wr_pend;
  logic [ADDR_W-1:0] w_win_ext;

  assign w_win_inc = r_win + WIN_W'(1);
  assign w_last    = (w_win_inc == r_num_win);
  assign w_win_ext = ADDR_W'(r_win);
  // r_cnt counts down; the read index counts up from 0 (full load) or 8 (activation reload)
  assign w_rd_idx  = 4'd15 - r_cnt;
  assign w_wr_idx  = w_rd_idx - 4'd1;
  assign w_wr_pend = r_full ? (r_cnt != 4'd15) : (r_cnt != 4'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_base  <= '0;
      r_a_base  <= '0;
      r_num_win <= '0;
      r_win     <= '0;
      r_cnt     <= '0;
      r_full    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_w_base  <= w_base;
            r_a_base  <= a_base;
            r_num_win <= num_win;
            r_win     <= '0;
            r_cnt     <= 4'd15;
            r_full    <= 1'b1;
          end
        end
        S_LOAD, S_COMP: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_TAIL, S_FILL: r_cnt <= 4'd7;
        S_CLR: begin
          r_win  <= w_win_inc;
          r_cnt  <= 4'd7;
          r_full <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    gb_rd_en     = 1'b0;
    gb_addr      = '0;
    write_w_PE   = 1'b0;
    write_a_PE   = 1'b0;
    comp         = 1'b0;
    shift        = 1'b0;
    clear        = 1'b0;
    comp_idx     = 3'd0;
    write_idx    = 3'd0;
    pe_out_valid = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (num_win == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        gb_rd_en = 1'b1;
        gb_addr  = w_rd_idx[3] ? (r_a_base + w_win_ext + ADDR_W'(w_rd_idx[2:0]))
                               : (r_w_base + ADDR_W'(w_rd_idx[2:0]));
        if (w_wr_pend) begin
          write_w_PE = ~w_wr_idx[3];
          write_a_PE = w_wr_idx[3];
          write_idx  = w_wr_idx[2:0];
        end
        if (r_cnt == 4'd0) w_state_nxt = S_TAIL;
      end
      S_TAIL: begin
        write_a_PE  = 1'b1;
        write_idx   = 3'd7;
        w_state_nxt = S_COMP;
      end
      S_COMP: begin
        comp      = 1'b1;
        comp_idx  = ~r_cnt[2:0];
        // nonzero write_idx keeps the PE accumulating
        write_idx = 3'd7;
        if (r_cnt == 4'd0) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        pe_out_valid = 1'b1;
        w_state_nxt  = S_CLR;
      end
      S_CLR: begin
        clear = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
        else begin
`ifdef PE_CTRL_WIN_SHIFT_EN
          w_state_nxt = S_SHIFT;
`else
          w_state_nxt = S_LOAD;
`endif
        end
      end
`ifdef PE_CTRL_WIN_SHIFT_EN
      S_SHIFT: begin
        shift       = 1'b1;
        gb_rd_en    = 1'b1;
        gb_addr     = r_a_base + w_win_ext + ADDR_W'(7);
        w_state_nxt = S_FILL;
      end
      S_FILL: begin
        write_a_PE  = 1'b1;
        write_idx   = 3'd7;
        w_state_nxt = S_COMP;
      end
`endif
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: per-cycle expected strobe/address trace built from
// the window timing rules, directed jobs plus randomized bases and window counts.
module tb_pe_seq_ctrl;
  localparam int MAXC = 8192;
`ifdef PE_CTRL_WIN_SHIFT_EN
  localparam int PER = 12;
`else
  localparam int PER = 19;
`endif

  logic        clk, rst_n, start;
  logic [15:0] w_base, a_base;
  logic [7:0]  num_win;
  logic        gb_rd_en;
  logic [15:0] gb_addr;
  logic        write_w_PE, write_a_PE, comp, shift, clear;
  logic [2:0]  comp_idx, write_idx;
  logic        pe_out_valid, busy, done;

  pe_seq_ctrl #(.ADDR_W(16), .WIN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_base(w_base), .a_base(a_base),
    .num_win(num_win), .gb_rd_en(gb_rd_en), .gb_addr(gb_addr), .write_w_PE(write_w_PE),
    .write_a_PE(write_a_PE), .comp(comp), .shift(shift), .clear(clear),
    .comp_idx(comp_idx), .write_idx(write_idx), .pe_out_valid(pe_out_valid),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  bit          e_rd[MAXC], e_ww[MAXC], e_wa[MAXC], e_cp[MAXC], e_sh[MAXC];
  bit          e_cl[MAXC], e_ov[MAXC], e_dn[MAXC], e_by[MAXC];
  logic [15:0] e_addr[MAXC];
  logic [2:0]  e_wi[MAXC], e_ci[MAXC];

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, gb_rd_en, gb_addr, write_w_PE, write_a_PE, comp, shift, clear,
            comp_idx, write_idx, pe_out_valid, busy, done};
  endfunction

  // Expected trace, indexed by cycle number (cycle 1 = first cycle after the accept edge)
  task automatic build(input logic [15:0] wb, input logic [15:0] ab, input int nw,
                       output int endc);
    int out_c, c0;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_ww[c] = 0; e_wa[c] = 0; e_cp[c] = 0; e_sh[c] = 0;
      e_cl[c] = 0; e_ov[c] = 0; e_dn[c] = 0; e_by[c] = 0;
      e_addr[c] = '0; e_wi[c] = '0; e_ci[c] = '0;
    end
    if (nw == 0) begin
      endc = 1;
    end else begin
      for (int k = 0; k < nw; k++) begin
        out_c = 26 + k * PER;
        if (k == 0) begin
          for (int i = 0; i < 16; i++) begin
            e_rd[1 + i]   = 1;
            e_addr[1 + i] = (i < 8) ? 16'(wb + 16'(i)) : 16'(ab + 16'(i - 8));
            if (i < 8) e_ww[2 + i] = 1;
            else       e_wa[2 + i] = 1;
            e_wi[2 + i] = 3'(i % 8);
          end
        end else begin
          c0 = 26 + (k - 1) * PER + 2;
`ifdef PE_CTRL_WIN_SHIFT_EN
          e_rd[c0]     = 1;
          e_sh[c0]     = 1;
          e_addr[c0]   = 16'(ab + 16'(k + 7));
          e_wa[c0 + 1] = 1;
          e_wi[c0 + 1] = 3'd7;
`else
          for (int i = 0; i < 8; i++) begin
            e_rd[c0 + i]     = 1;
            e_addr[c0 + i]   = 16'(ab + 16'(k + i));
            e_wa[c0 + i + 1] = 1;
            e_wi[c0 + i + 1] = 3'(i);
          end
`endif
        end
        for (int j = 0; j < 8; j++) begin
          e_cp[out_c - 8 + j] = 1;
          e_ci[out_c - 8 + j] = 3'(j);
          e_wi[out_c - 8 + j] = 3'd7;
        end
        e_ov[out_c]     = 1;
        e_cl[out_c + 1] = 1;
      end
      endc = 26 + (nw - 1) * PER + 2;
    end
    e_dn[endc] = 1;
    for (int c = 1; c <= endc; c++) e_by[c] = 1;
  endtask

  task automatic run_job(input logic [15:0] wb, input logic [15:0] ab, input int nw,
                         input int inj, input int abort_c);
    int endc;
    build(wb, ab, nw, endc);
    @(negedge clk);
    w_base = wb; a_base = ab; num_win = 8'(nw); start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= endc + 1; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == abort_c) begin
        rst_n = 1'b0;
        #1;
        chk("rst_outs", c, all_outs(), 32'd0);
        break;
      end
      chk("gb_rd_en", c, 32'(gb_rd_en), 32'(e_rd[c]));
      if (e_rd[c]) chk("gb_addr", c, 32'(gb_addr), 32'(e_addr[c]));
      chk("write_w", c, 32'(write_w_PE), 32'(e_ww[c]));
      chk("write_a", c, 32'(write_a_PE), 32'(e_wa[c]));
      if (e_ww[c] || e_wa[c] || e_cp[c]) chk("write_idx", c, 32'(write_idx), 32'(e_wi[c]));
      chk("comp", c, 32'(comp), 32'(e_cp[c]));
      if (e_cp[c]) chk("comp_idx", c, 32'(comp_idx), 32'(e_ci[c]));
      chk("shift", c, 32'(shift), 32'(e_sh[c]));
      chk("clear", c, 32'(clear), 32'(e_cl[c]));
      chk("out_valid", c, 32'(pe_out_valid), 32'(e_ov[c]));
      chk("done", c, 32'(done), 32'(e_dn[c]));
      chk("busy", c, 32'(busy), 32'(e_by[c]));
      chk("strobe_onehot", c,
          32'($countones({write_w_PE, write_a_PE, comp, shift, clear}) <= 1), 32'd1);
      if (c == inj) begin
        start = 1'b1; a_base = ~ab; w_base = ~wb; num_win = 8'(nw + 3);
      end else if (c == inj + 1) begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    int nw, inj;
    rst_n = 1'b0; start = 1'b0; w_base = '0; a_base = '0; num_win = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 0, all_outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", 0, all_outs(), 32'd0);

    run_job(16'h0100, 16'h0200, 1, 0, 0);
    run_job(16'h0100, 16'h0200, 3, 0, 0);
    run_job(16'h0100, 16'h0200, 0, 0, 0);
    run_job(16'($urandom), 16'($urandom), 3, 30, 0);

    run_job(16'h0100, 16'h0200, 3, 0, 26 + PER - 3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", i, {30'd0, busy, done}, 32'd0);
    end
    run_job(16'h0100, 16'h0200, 1, 0, 0);

    run_job(16'hFFF8, 16'hFFFA, 4, 0, 0);
    for (int j = 0; j < 6; j++) begin
      nw  = int'($urandom_range(0, 5));
      inj = (nw == 0) ? 0 : int'($urandom_range(2, 20));
      run_job(16'($urandom), 16'($urandom), nw, inj, 0);
    end
    run_job(16'($urandom), 16'($urandom), 255, 100, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
